dmem_arbiter: RTL



---
 rtl/dmem_arbiter_pkg.sv | 21 ++
 rtl/dmem_arbiter_rr_picker.sv | 31 +++
 rtl/dmem_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int BUS_W       = 32;
  localparam int DMEM_DEPTH  = 32;
  localparam int DMEM_ADDR_W = 6;

  typedef logic [BUS_W-1:0] bus_type;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } dmem_state_t;

  // Index width for a requester count; at least one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// Combinational round-robin selector: first set req after last_winner, wrapping.
module rr_picker
  import dmem_arbiter_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int IDXW  = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDXW-1:0]  last_winner,
  output logic [N_REQ-1:0] winner,
  output logic [IDXW-1:0]  winner_idx,
  output logic             any
);

  always_comb begin
    int j;
    winner     = '0;
    winner_idx = '0;
    any        = 1'b0;
    j          = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      j = (int'(last_winner) + i) % N_REQ;
      if (!any && req[j]) begin
        any        = 1'b1;
        winner[j]  = 1'b1;
        winner_idx = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one registered-read data memory between N_REQ ports.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int ADDR_W = DMEM_ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0]              we,
  input  logic [N_REQ-1:0][ADDR_W-1:0]  addr,
  input  bus_type [N_REQ-1:0]           wdata,
  output logic [N_REQ-1:0]              gnt,
  output logic [N_REQ-1:0]              rvalid,
  output bus_type                       rdata,
  output logic                          err,
  output logic [ADDR_W-1:0]             mem_address,
  output bus_type                       mem_input_data,
  output logic                          mem_enable_read,
  output logic                          mem_enable_write,
  input  bus_type                       mem_read_data
);

  localparam int IDXW = idx_w(N_REQ);

  dmem_state_t       state, state_nxt;
  logic [IDXW-1:0]   last_winner;
  logic [N_REQ-1:0]  pick_oh;
  logic [IDXW-1:0]   pick_idx;
  logic              pick_any;

  // Access captured in IDLE and replayed during ISSUE/RESP
  logic [N_REQ-1:0]  win_oh;
  logic              lat_we;
  logic              lat_oor;
  logic [ADDR_W-1:0] lat_addr;
  bus_type           lat_wdata;
  logic              pick_oor;

  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req         (req),
    .last_winner (last_winner),
    .winner      (pick_oh),
    .winner_idx  (pick_idx),
    .any         (pick_any)
  );

  assign pick_oor = {1'b0, addr[pick_idx]} >= (ADDR_W+1)'(DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_winner <= IDXW'(N_REQ-1);
      rvalid      <= '0;
      rdata       <= '0;
      win_oh      <= '0;
      lat_we      <= 1'b0;
      lat_oor     <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
    end else begin
      state  <= state_nxt;
      rvalid <= (state == RESP) ? win_oh : '0;
      if (state == RESP)
        rdata <= lat_oor ? '0 : mem_read_data;
      if (state == IDLE && pick_any) begin
        win_oh      <= pick_oh;
        last_winner <= pick_idx;
        lat_we      <= we[pick_idx];
        lat_oor     <= pick_oor;
        lat_addr    <= addr[pick_idx];
        lat_wdata   <= wdata[pick_idx];
      end
    end
  end

  // Grant, error and enables are state-decoded and masked by rst so an
  // ISSUE cycle hit by reset produces no visible access.
  always_comb begin
    state_nxt        = state;
    gnt              = '0;
    err              = 1'b0;
    mem_enable_read  = 1'b0;
    mem_enable_write = 1'b0;
    mem_address      = lat_addr;
    mem_input_data   = lat_wdata;
    case (state)
      IDLE: if (pick_any) state_nxt = ISSUE;
      ISSUE: begin
        if (!rst) begin
          gnt              = win_oh;
          err              = lat_oor;
          mem_enable_write = lat_we && !lat_oor;
          mem_enable_read  = !lat_we && !lat_oor;
        end
        state_nxt = lat_we ? IDLE : RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule
